// File: rtl/aes_sbox_rom.sv
// Registered AES forward S-box lookup (FIPS-197 SubBytes), one cycle latency.
// Optional `SBOX_PARITY_EN adds parity_o, the registered parity of the looked-up entry.
module aes_sbox_rom #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] rom_addr,
    output logic [width_p-1:0] data_o,
`ifdef SBOX_PARITY_EN
    output logic               parity_o,
`endif
    output logic               v_o
);

    if (width_p != 8) begin : g_bad_width
        $error("aes_sbox_rom: width_p must be 8");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] data_d, data_q;
    logic       v_d, v_q;

    // data_o holds across idle cycles; only the valid flag tracks v_i every edge.
    always_comb begin
        v_d    = v_i;
        data_d = data_q;
        if (v_i) begin
            data_d = SBOX[rom_addr[7:0]];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= 8'h00;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data_o = data_q;
    assign v_o    = v_q;

`ifdef SBOX_PARITY_EN
    // Parity comes from the table entry itself, so a flipped data_q bit shows as a mismatch.
    logic parity_d, parity_q;

    always_comb begin
        parity_d = parity_q;
        if (v_i) begin
            parity_d = ^SBOX[rom_addr[7:0]];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_aes_sbox_rom.sv
// Self-checking bench for aes_sbox_rom: directed vectors, reset behaviour and a full sweep
// against an S-box computed from GF(2^8) inversion plus the affine transform.
module tb_aes_sbox_rom;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       v_i;
    logic [7:0] rom_addr;
    logic [7:0] data_o;
    logic       v_o;
`ifdef SBOX_PARITY_EN
    logic       parity_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] ref_sbox [256];
    logic [7:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    aes_sbox_rom #(.width_p(8)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .rom_addr (rom_addr),
        .data_o   (data_o),
`ifdef SBOX_PARITY_EN
        .parity_o (parity_o),
`endif
        .v_o      (v_o)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Present one cycle of inputs, then sample just after the edge that consumes them.
    task automatic drive(input logic v, input logic [7:0] a);
        v_i      = v;
        rom_addr = a;
        @(posedge clk_i);
        #1;
    endtask

    logic [7:0] spot_a [7] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'h64, 8'h80, 8'hff};
    logic [7:0] spot_e [7] = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'h43, 8'hcd, 8'h16};

    initial begin
        for (int i = 0; i < 256; i++) ref_sbox[i] = model_sbox(8'(i));

        reset_i  = 1'b1;
        v_i      = 1'b1;
        rom_addr = 8'h53;
        #1;
        check("reset_data", data_o, 8'h00);
        check("reset_v", {7'b0, v_o}, 8'h00);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_hold_data", data_o, 8'h00);
        check("reset_hold_v", {7'b0, v_o}, 8'h00);
        reset_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, spot_a[i]);
            check($sformatf("spot_%02h", spot_a[i]), data_o, spot_e[i]);
            check($sformatf("spot_v_%02h", spot_a[i]), {7'b0, v_o}, 8'h01);
`ifdef SBOX_PARITY_EN
            check($sformatf("spot_par_%02h", spot_a[i]), {7'b0, parity_o}, {7'b0, ^spot_e[i]});
`endif
        end

        // Async reset between edges while v_o is high.
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_data", data_o, 8'h00);
        check("async_rst_v", {7'b0, v_o}, 8'h00);
`ifdef SBOX_PARITY_EN
        check("async_rst_par", {7'b0, parity_o}, 8'h00);
`endif
        drive(1'b1, 8'h10);
        check("rst_held_data", data_o, 8'h00);
        check("rst_held_v", {7'b0, v_o}, 8'h00);
        reset_i = 1'b0;

        drive(1'b1, 8'h64);
        check("hold_first", data_o, 8'h43);
`ifdef SBOX_PARITY_EN
        check("par_64", {7'b0, parity_o}, 8'h01);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i % 2 == 0) ? 8'h00 : 8'hff);
            check("hold_data", data_o, 8'h43);
            check("hold_v", {7'b0, v_o}, 8'h00);
`ifdef SBOX_PARITY_EN
            check("hold_par", {7'b0, parity_o}, 8'h01);
`endif
        end

        // Reset lands before the edge that would have returned 0x53.
        v_i      = 1'b1;
        rom_addr = 8'h53;
        #2;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mid_rst_v", {7'b0, v_o}, 8'h00);
        check("mid_rst_data", data_o, 8'h00);
        reset_i = 1'b0;
        v_i     = 1'b0;
        drive(1'b0, 8'h53);
        check("after_rst_idle_v", {7'b0, v_o}, 8'h00);
        drive(1'b1, 8'h01);
        check("after_rst_data", data_o, 8'h7c);
        check("after_rst_v", {7'b0, v_o}, 8'h01);

        // Back-to-back sweep; every cycle must deliver the next expected byte.
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(ref_sbox[i]);
            drive(1'b1, 8'(i));
            check($sformatf("sweep_v_%02h", i), {7'b0, v_o}, 8'h01);
            if (exp_q.size() > 0) begin
                check($sformatf("sweep_%02h", i), data_o, exp_q.pop_front());
            end
`ifdef SBOX_PARITY_EN
            check($sformatf("sweep_par_%02h", i), {7'b0, parity_o}, {7'b0, ^data_o});
`endif
        end
        drive(1'b0, 8'h00);
        check("sweep_end_v", {7'b0, v_o}, 8'h00);
        check("sweep_end_hold", data_o, 8'h16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
